// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: the master drives the write/read requests,
// and the FIFO (slave) returns data, occupancy and status flags.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr, din, rd,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr, din, rd,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO for UART TX/RX byte buffering: simultaneous read/write,
// registered or first-word-fall-through output, occupancy count, threshold and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] raddr_reg;
    logic [AW-1:0] raddr_next;
    logic [AW-1:0] waddr_reg;
    logic [AW-1:0] waddr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          overflow_next;
    logic          underflow_reg;
    logic          underflow_next;

    logic empty;
    logic full;
    logic rd_ok;
    logic wr_ok;

    // Flags are pure functions of the occupancy register, so they move in the same cycle as count.
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // A write into a full FIFO is still accepted when a read frees the head slot in the same cycle.
    assign rd_ok = bus.rd & ~empty;
    assign wr_ok = bus.wr & (~full | rd_ok);

    always_comb begin
        raddr_next     = raddr_reg;
        waddr_next     = waddr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (bus.flush) begin
            raddr_next     = '0;
            waddr_next     = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (rd_ok) begin
                raddr_next = raddr_reg + 1'b1;
            end
            if (wr_ok) begin
                waddr_next = waddr_reg + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (bus.wr && !wr_ok) begin
                overflow_next = 1'b1;
            end
            if (bus.rd && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_reg     <= '0;
            waddr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            raddr_reg     <= raddr_next;
            waddr_reg     <= waddr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage carries no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.flush) begin
            mem[waddr_reg] <= bus.din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = mem[raddr_reg];
        end else begin : g_registered
            logic [WIDTH-1:0] dout_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (rd_ok && !bus.flush) begin
                    dout_reg <= mem[raddr_reg];
                end
            end

            assign bus.dout = dout_reg;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule
